// File: rtl/move_scheduler.sv
// Falling-piece motion sequencer: arbitrates gravity ticks and key moves onto the
// shared collision checker and commits accepted moves to the piece registers.
module move_scheduler #(
    parameter int         GRAVITY_DIV = 50000000,
    parameter logic [3:0] SPAWN_X     = 4'd4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] keycode,
    input  logic       key_valid,
    input  logic       game_active,
    input  logic       spawn,
    output logic       chk_req,
    output logic [3:0] chk_x,
    output logic [4:0] chk_y,
    output logic [1:0] chk_rot,
    input  logic       chk_ack,
    input  logic       chk_collision,
    output logic [3:0] piece_x,
    output logic [4:0] piece_y,
    output logic [1:0] piece_rot,
    output logic       place_piece,
    output logic       spawn_fail,
    output logic       busy
);
    typedef enum logic [1:0] {HOLD, IDLE, CHECK, LOCK} state_t;
    typedef enum logic [2:0] {OP_DOWN, OP_LEFT, OP_RIGHT, OP_ROTATE, OP_DROP, OP_SPAWN} op_t;

    localparam int               CNT_W    = $clog2(GRAVITY_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GRAVITY_DIV - 1);

    state_t           state;
    op_t              op, slot_op, key_op, sel_op;
    logic             slot_valid, grav_pend, key_known;
    logic [CNT_W-1:0] grav_cnt;
    logic             active, load_key, take, commit_down, rest_next;
    logic [3:0]       nx;
    logic [4:0]       ny;
    logic [1:0]       nr;

    // Checker handshake: chk_req with chk_x/y/rot is held until chk_ack is sampled.
    assign busy        = (state == CHECK) || (state == LOCK);
    assign active      = ((state == IDLE) || (state == CHECK)) && game_active;
    assign load_key    = active && key_valid && key_known;
    assign take        = (state == IDLE) && game_active && (grav_pend || slot_valid);
    assign commit_down = (state == CHECK) && chk_ack && !chk_collision
                         && ((op == OP_DOWN) || (op == OP_DROP));
    assign rest_next   = (state == LOCK) || ((state == CHECK) && chk_ack && chk_collision
                         && ((op == OP_DOWN) || (op == OP_DROP) || (op == OP_SPAWN)));

    always_comb begin
        key_known = 1'b1;
        key_op    = OP_DOWN;
        case (keycode)
            8'h6B:   key_op = OP_LEFT;
            8'h74:   key_op = OP_RIGHT;
            8'h72:   key_op = OP_DOWN;
            8'h75:   key_op = OP_ROTATE;
            8'h29:   key_op = OP_DROP;
            default: key_known = 1'b0;
        endcase
    end

    // Gravity outranks the key slot; candidates wrap and the checker rejects off-board ones.
    always_comb begin
        sel_op = grav_pend ? OP_DOWN : slot_op;
        nx     = piece_x;
        ny     = piece_y;
        nr     = piece_rot;
        case (sel_op)
            OP_LEFT:   nx = piece_x - 4'd1;
            OP_RIGHT:  nx = piece_x + 4'd1;
            OP_ROTATE: nr = piece_rot + 2'd1;
            default:   ny = piece_y + 5'd1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_valid <= 1'b0;
            slot_op    <= OP_DOWN;
        end else if (rest_next) begin
            slot_valid <= 1'b0;
        end else if (load_key) begin
            slot_valid <= 1'b1;
            slot_op    <= key_op;
        end else if (take && !grav_pend) begin
            slot_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grav_cnt  <= '0;
            grav_pend <= 1'b0;
        end else if (commit_down) begin
            grav_cnt  <= '0;
            grav_pend <= 1'b0;
        end else begin
            if (!active || grav_cnt == CNT_LAST) grav_cnt <= '0;
            else                                 grav_cnt <= grav_cnt + 1'b1;
            if (rest_next)                              grav_pend <= 1'b0;
            else if (active && grav_cnt == CNT_LAST)    grav_pend <= 1'b1;
            else if (take && grav_pend)                 grav_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HOLD;
            op          <= OP_DOWN;
            chk_req     <= 1'b0;
            chk_x       <= '0;
            chk_y       <= '0;
            chk_rot     <= '0;
            piece_x     <= '0;
            piece_y     <= '0;
            piece_rot   <= '0;
            place_piece <= 1'b0;
            spawn_fail  <= 1'b0;
        end else begin
            place_piece <= 1'b0;
            spawn_fail  <= 1'b0;
            case (state)
                HOLD: if (spawn) begin
                    op      <= OP_SPAWN;
                    chk_x   <= SPAWN_X;
                    chk_y   <= '0;
                    chk_rot <= '0;
                    chk_req <= 1'b1;
                    state   <= CHECK;
                end
                IDLE: if (take) begin
                    op      <= sel_op;
                    chk_x   <= nx;
                    chk_y   <= ny;
                    chk_rot <= nr;
                    chk_req <= 1'b1;
                    state   <= CHECK;
                end
                CHECK: if (chk_ack) begin
                    chk_req <= 1'b0;
                    if (!chk_collision) begin
                        piece_x   <= chk_x;
                        piece_y   <= chk_y;
                        piece_rot <= chk_rot;
                        // A hard drop keeps probing one row lower without leaving CHECK.
                        if (op == OP_DROP) begin
                            chk_y   <= chk_y + 5'd1;
                            chk_req <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (op == OP_SPAWN) begin
                        spawn_fail <= 1'b1;
                        state      <= HOLD;
                    end else if ((op == OP_DOWN) || (op == OP_DROP)) begin
                        place_piece <= 1'b1;
                        state       <= LOCK;
                    end else begin
                        state <= IDLE;
                    end
                end
                LOCK:    state <= HOLD;
                default: state <= HOLD;
            endcase
        end
    end
endmodule

// File: tb/tb_move_scheduler.sv
// Directed bench for move_scheduler: a slow-gravity instance for key/drop/spawn
// behaviour and a GRAVITY_DIV=8 instance for gravity timing and arbitration.
module tb_move_scheduler;
    logic       clk = 1'b0;
    logic       rst_n, game_active, key_valid, spawn;
    logic [7:0] keycode;
    logic       chk_req, chk_ack, chk_collision;
    logic [3:0] chk_x, piece_x;
    logic [4:0] chk_y, piece_y;
    logic [1:0] chk_rot, piece_rot;
    logic       place_piece, spawn_fail, busy;

    logic       g_rst_n, g_game_active, g_key_valid, g_spawn;
    logic [7:0] g_keycode;
    logic       g_chk_req, g_chk_ack, g_chk_collision;
    logic [3:0] g_chk_x, g_piece_x;
    logic [4:0] g_chk_y, g_piece_y;
    logic [1:0] g_chk_rot, g_piece_rot;
    logic       g_place_piece, g_spawn_fail, g_busy;

    // Checker model: a 10-column board, optional floor row, optional forced collision.
    logic force_coll = 1'b0, ack_delay_en = 1'b0, ack_late = 1'b0;
    int   coll_row = 99, req_age = 0;

    int errors = 0, checks = 0;
    int n, hold, stable, commits, reqs, places, both, n_fail, gap;
    logic [4:0] prev_y;
    logic [3:0] last_cx;
    int         place_seen;
    logic [3:0] exp_q[$];
    logic [7:0] move_codes [3] = '{8'h6B, 8'h6B, 8'h74};

    always #5 clk = ~clk;

    assign chk_ack       = ack_delay_en ? ack_late : chk_req;
    assign chk_collision = chk_ack && (force_coll || (chk_x > 4'd9) || (int'(chk_y) >= coll_row));
    assign g_chk_ack       = g_chk_req;
    assign g_chk_collision = 1'b0;

    // Late-ack responder: ack on the fourth cycle chk_req is seen high.
    always @(negedge clk) begin
        if (!chk_req) begin
            req_age  = 0;
            ack_late = 1'b0;
        end else begin
            req_age  = req_age + 1;
            ack_late = (req_age == 4);
        end
    end

    move_scheduler #(.GRAVITY_DIV(1000), .SPAWN_X(4'd4)) dut (
        .clk(clk), .rst_n(rst_n), .keycode(keycode), .key_valid(key_valid),
        .game_active(game_active), .spawn(spawn), .chk_req(chk_req), .chk_x(chk_x),
        .chk_y(chk_y), .chk_rot(chk_rot), .chk_ack(chk_ack), .chk_collision(chk_collision),
        .piece_x(piece_x), .piece_y(piece_y), .piece_rot(piece_rot),
        .place_piece(place_piece), .spawn_fail(spawn_fail), .busy(busy)
    );

    move_scheduler #(.GRAVITY_DIV(8), .SPAWN_X(4'd4)) dut_g (
        .clk(clk), .rst_n(g_rst_n), .keycode(g_keycode), .key_valid(g_key_valid),
        .game_active(g_game_active), .spawn(g_spawn), .chk_req(g_chk_req), .chk_x(g_chk_x),
        .chk_y(g_chk_y), .chk_rot(g_chk_rot), .chk_ack(g_chk_ack),
        .chk_collision(g_chk_collision), .piece_x(g_piece_x), .piece_y(g_piece_y),
        .piece_rot(g_piece_rot), .place_piece(g_place_piece), .spawn_fail(g_spawn_fail),
        .busy(g_busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    task automatic press_key(input logic [7:0] code);
        @(negedge clk);
        keycode   = code;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        keycode   = 8'h00;
    endtask

    task automatic g_press_key(input logic [7:0] code);
        @(negedge clk);
        g_keycode   = code;
        g_key_valid = 1'b1;
        @(negedge clk);
        g_key_valid = 1'b0;
        g_keycode   = 8'h00;
    endtask

    task automatic do_spawn();
        @(negedge clk);
        spawn = 1'b1;
        @(negedge clk);
        spawn = 1'b0;
    endtask

    task automatic wait_settle(input string tag);
        int k;
        k = 0;
        while (!busy && k < 20) begin @(negedge clk); k++; end
        if (!busy) begin
            check_eq({tag, "_start_timeout"}, busy, 1);
            return;
        end
        while (busy && k < 60) begin
            last_cx = chk_x;
            if (place_piece) place_seen++;
            @(negedge clk);
            k++;
        end
        if (busy) check_eq({tag, "_end_timeout"}, busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; game_active = 1'b0; key_valid = 1'b0; keycode = 8'h00; spawn = 1'b0;
        g_rst_n = 1'b0; g_game_active = 1'b0; g_key_valid = 1'b0; g_keycode = 8'h00;
        g_spawn = 1'b0;
        tick(2);
        check_eq("reset_outputs", {chk_req, chk_x, chk_y, chk_rot, piece_x, piece_y, piece_rot,
                 place_piece, spawn_fail, busy}, 32'd0);
        rst_n = 1'b1; g_rst_n = 1'b1; game_active = 1'b1;
        tick(1);

        press_key(8'h6B);
        tick(3);
        check_eq("hold_ignores_key", {busy, chk_req, piece_x}, 32'd0);

        do_spawn();
        check_eq("spawn_req", {chk_req, busy, chk_x, chk_y, chk_rot}, {1'b1, 1'b1, 4'd4, 5'd0, 2'd0});
        @(negedge clk);
        check_eq("spawn_commit", {piece_x, piece_y, piece_rot, busy, chk_req},
                 {4'd4, 5'd0, 2'd0, 2'b00});

        exp_q = '{4'd3, 4'd2, 4'd3};
        for (int i = 0; i < 3; i++) begin
            press_key(move_codes[i]);
            wait_settle("move");
            check_eq("move_x", piece_x, exp_q.pop_front());
        end

        // Left from x=3 with a late ack: request and candidate must hold until acked.
        ack_delay_en = 1'b1;
        press_key(8'h6B);
        n = 0; hold = 0; stable = 1;
        while (!chk_req && n < 10) begin @(negedge clk); n++; end
        while (chk_req && n < 30) begin
            hold++;
            if (chk_x != 4'd2 || chk_y != 5'd0 || chk_rot != 2'd0 || piece_x != 4'd3) stable = 0;
            @(negedge clk);
            n++;
        end
        check_eq("late_ack_hold_cycles", hold, 4);
        check_eq("late_ack_stable", stable, 1);
        check_eq("late_ack_commit", {piece_x, busy, chk_req}, {4'd2, 2'b00});
        ack_delay_en = 1'b0;

        press_key(8'h6B); wait_settle("left1");
        press_key(8'h6B); wait_settle("left2");
        check_eq("at_left_wall", piece_x, 0);
        place_seen = 0;
        press_key(8'h6B); wait_settle("wall");
        check_eq("wall_cand_wraps", last_cx, 15);
        check_eq("wall_blocked_x", piece_x, 0);
        check_eq("wall_no_place", place_seen, 0);

        exp_q = '{4'd1, 4'd2, 4'd3, 4'd0};
        for (int i = 0; i < 4; i++) begin
            press_key(8'h75);
            wait_settle("rotate");
            check_eq("rotate", piece_rot, exp_q.pop_front());
        end

        // Hard drop onto a floor at row 18.
        coll_row = 18;
        press_key(8'h29);
        n = 0; commits = 0; reqs = 0; places = 0; both = 0; prev_y = piece_y;
        while (places == 0 && n < 60) begin
            @(negedge clk);
            n++;
            if (piece_y == prev_y + 5'd1) commits++;
            prev_y = piece_y;
            if (chk_req) reqs++;
            if (place_piece) places++;
            if (place_piece && spawn_fail) both++;
        end
        check_eq("drop_place_seen", places, 1);
        check_eq("drop_commits", commits, 17);
        check_eq("drop_requests", reqs, 18);
        check_eq("drop_final", {piece_x, piece_y, piece_rot, busy}, {4'd0, 5'd17, 2'd0, 1'b1});
        @(negedge clk);
        check_eq("drop_to_hold", {place_piece, busy, chk_req, spawn_fail}, 32'd0);
        coll_row = 99;

        force_coll = 1'b1;
        do_spawn();
        n_fail = 0;
        repeat (4) begin
            if (spawn_fail) n_fail++;
            if (spawn_fail && place_piece) both++;
            @(negedge clk);
        end
        check_eq("spawn_fail_pulses", n_fail, 1);
        check_eq("no_place_with_fail", both, 0);
        check_eq("spawn_fail_regs", {piece_x, piece_y, piece_rot, busy}, {4'd0, 5'd17, 2'd0, 1'b0});
        force_coll = 1'b0;
        do_spawn();
        @(negedge clk);
        check_eq("respawn_from_hold", {piece_x, piece_y, piece_rot, busy}, {4'd4, 5'd0, 2'd0, 1'b0});

        // Right then rotate arrive while a left is in flight: only the rotate survives.
        ack_delay_en = 1'b1;
        press_key(8'h6B);
        press_key(8'h74);
        press_key(8'h75);
        n = 0;
        while (busy && n < 20) begin @(negedge clk); n++; end
        check_eq("inflight_left", piece_x, 3);
        wait_settle("last_key");
        check_eq("last_key_only", {piece_x, piece_rot}, {4'd3, 2'd1});
        reqs = 0;
        repeat (8) begin
            if (chk_req) reqs++;
            @(negedge clk);
        end
        check_eq("older_key_dropped", reqs, 0);
        ack_delay_en = 1'b0;

        g_game_active = 1'b1;
        @(negedge clk); g_spawn = 1'b1;
        @(negedge clk); g_spawn = 1'b0;
        @(negedge clk);
        check_eq("g_spawn", {g_piece_x, g_piece_y, g_busy}, {4'd4, 5'd0, 1'b0});
        gap = 0;
        while (!g_chk_req && gap < 40) begin @(negedge clk); gap++; end
        check_eq("g_first_gap", gap, 8);
        check_eq("g_first_cand", {g_chk_x, g_chk_y, g_chk_rot}, {4'd4, 5'd1, 2'd0});
        // A gravity commit clears the counter, so the next tick fires 8 cycles after it.
        @(negedge clk);
        gap = 1;
        while (!g_chk_req && gap < 40) begin @(negedge clk); gap++; end
        check_eq("g_period", gap, 10);
        check_eq("g_second", {g_piece_y, g_chk_y}, {5'd1, 5'd2});
        tick(7);
        g_press_key(8'h6B);
        @(negedge clk);
        check_eq("g_tick_first", {g_chk_req, g_chk_x, g_chk_y}, {1'b1, 4'd4, 5'd3});
        tick(2);
        check_eq("g_key_second", {g_chk_req, g_chk_x, g_chk_y}, {1'b1, 4'd3, 5'd3});
        @(negedge clk);
        check_eq("g_key_commit", {g_piece_x, g_piece_y}, {4'd3, 5'd3});

        ack_delay_en = 1'b1;
        press_key(8'h74);
        n = 0;
        while (!chk_req && n < 10) begin @(negedge clk); n++; end
        check_eq("midcheck_req", chk_req, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midcheck_reset", {chk_req, chk_x, chk_y, chk_rot, piece_x, piece_y, piece_rot,
                 place_piece, spawn_fail, busy}, 32'd0);
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
